// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings and the manager FSM state type.
//   Contents:
//     HTRANS_*  : transfer type codes (IDLE/BUSY/NONSEQ/SEQ)
//     HBURST_*  : burst type codes (SINGLE/INCR/INCR4/INCR8/INCR16)
//     HRESP_*   : response codes (OKAY/ERROR)
//     mgr_state_t : manager FSM states
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAITW = 3'd2,
        ST_DLAST = 3'd3,
        ST_ERR   = 3'd4
    } mgr_state_t;

endpackage

// File: rtl/ahb_mgr_addr_gen.sv
// ---------------------------------------------------------------------------
// ahb_mgr_addr_gen
//   Purely combinational address helper for ahb_lite_manager.
//   Ports:
//     cur_addr/cur_size      : address and size of the beat being driven
//     next_addr              : address of the following beat (incrementing)
//     at_1k                  : current beat starts on a 1KB boundary
//     start_addr/size/len    : command being accepted
//     start_burst            : HBURST to use for that command
// ---------------------------------------------------------------------------
module ahb_mgr_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_W      = 5
)(
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            cur_size,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [2:0]            start_size,
    input  logic [LEN_W-1:0]      start_len,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  at_1k,
    output logic [2:0]            start_burst
);

    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  start_cross;

    always_comb begin
        next_addr = cur_addr + (ADDR_WIDTH'(1) << cur_size);
        at_1k     = (cur_addr[9:0] == 10'd0);

        // Byte address of the final byte of the command decides whether a
        // fixed-length burst would straddle a 1KB region.
        span        = ADDR_WIDTH'(start_len) << start_size;
        last_addr   = start_addr + span - ADDR_WIDTH'(1);
        start_cross = (start_addr[ADDR_WIDTH-1:10] != last_addr[ADDR_WIDTH-1:10]);

        start_burst = HBURST_INCR;
        if (32'(start_len) == 32'd1) begin
            start_burst = HBURST_SINGLE;
        end else if (!start_cross) begin
            if (32'(start_len) == 32'd4) begin
                start_burst = HBURST_INCR4;
            end else if (32'(start_len) == 32'd8) begin
                start_burst = HBURST_INCR8;
            end else if (32'(start_len) == 32'd16) begin
                start_burst = HBURST_INCR16;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_manager.sv
// ---------------------------------------------------------------------------
// ahb_lite_manager
//   AHB-Lite manager converting a command/data stream into SINGLE and
//   INCR-family transfers, with wait states, two-cycle ERROR, BUSY on
//   write-data underflow and 1KB boundary splitting.
//   Ports:
//     HCLK, HRESETn           : clock, asynchronous active-low reset
//     cmd_*                   : command request (valid/ready handshake)
//     wr_data/wr_valid/wr_ready : write beat stream
//     rd_data/rd_valid        : read beat stream (no backpressure)
//     done/done_err           : end-of-command pulse and error flag
//     H*                      : AHB-Lite manager bus signals
//   Optional feature macro AHB_MGR_MASTLOCK_EN adds cmd_lock / HMASTLOCK.
//   Write data sources must hold wr_valid/wr_data until wr_ready.
// ---------------------------------------------------------------------------
module ahb_lite_manager
    import ahb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         MAX_LEN    = 16,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
)(
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [2:0]                cmd_size,
    input  logic [$clog2(MAX_LEN):0]  cmd_len,
`ifdef AHB_MGR_MASTLOCK_EN
    input  logic                      cmd_lock,
    output logic                      HMASTLOCK,
`endif
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      done,
    output logic                      done_err,
    output logic [ADDR_WIDTH-1:0]     HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [DATA_WIDTH-1:0]     HWDATA,
    input  logic [DATA_WIDTH-1:0]     HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    mgr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [2:0]            burst_q, burst_d;
    logic [LEN_W-1:0]      beats_q, beats_d;      // address phases still to issue
    logic                  first_q, first_d;      // next beat is the first of the command
    logic                  pend_q, pend_d;        // transfer presented while HREADY low
    logic                  dphase_q, dphase_d;    // a real data phase is in progress
    logic                  dwrite_q, dwrite_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  done_q, done_d;
    logic                  done_err_q, done_err_d;
`ifdef AHB_MGR_MASTLOCK_EN
    logic                  lock_q, lock_d;
`endif

    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  at_1k;
    logic [2:0]            start_burst;
    logic                  in_addr;
    logic                  err_first;
    logic                  issue;
    logic                  drive_xfer;
    logic                  accept;
    logic [1:0]            htrans;

    ahb_mgr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_W      (LEN_W)
    ) u_addr_gen (
        .cur_addr    (addr_q),
        .cur_size    (size_q),
        .start_addr  (cmd_addr),
        .start_size  (cmd_size),
        .start_len   (cmd_len),
        .next_addr   (next_addr),
        .at_1k       (at_1k),
        .start_burst (start_burst)
    );

    // The done cycle still counts as busy so a command is never accepted
    // in the same cycle the previous one reports completion.
    assign cmd_ready = (state_q == ST_IDLE) && !done_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        burst_d    = burst_q;
        beats_d    = beats_q;
        first_d    = first_q;
        pend_d     = pend_q;
        dphase_d   = dphase_q;
        dwrite_d   = dwrite_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        wr_ready   = 1'b0;
`ifdef AHB_MGR_MASTLOCK_EN
        lock_d     = lock_q;
`endif

        in_addr   = (state_q == ST_ADDR) || (state_q == ST_WAITW);
        // First ERROR cycle: the pending address must be withdrawn at once.
        err_first = dphase_q && !HREADY && (HRESP == HRESP_ERROR);
        // Once a write transfer is on the bus with HREADY low it stays there.
        issue      = !write_q || wr_valid || pend_q;
        drive_xfer = in_addr && issue && !err_first;
        accept     = drive_xfer && HREADY;

        htrans = HTRANS_IDLE;
        if (drive_xfer) begin
            htrans = (first_q || at_1k) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end else if (in_addr && !first_q && !err_first) begin
            htrans = HTRANS_BUSY;
        end

        if (dphase_q && !dwrite_q && HREADY && (HRESP == HRESP_OKAY)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
        end
        if (HREADY) begin
            dphase_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_ADDR;
                    addr_d  = cmd_addr;
                    size_d  = cmd_size;
                    write_d = cmd_write;
                    burst_d = start_burst;
                    beats_d = LEN_W'(cmd_len);
                    first_d = 1'b1;
                    pend_d  = 1'b0;
`ifdef AHB_MGR_MASTLOCK_EN
                    lock_d  = cmd_lock;
`endif
                end
            end
            ST_ADDR, ST_WAITW: begin
                if (err_first) begin
                    state_d  = ST_ERR;
                    dphase_d = 1'b0;
                    pend_d   = 1'b0;
                end else if (accept) begin
                    dphase_d = 1'b1;
                    dwrite_d = write_q;
                    addr_d   = next_addr;
                    beats_d  = beats_q - LEN_W'(1);
                    first_d  = 1'b0;
                    pend_d   = 1'b0;
                    if (write_q) begin
                        wr_ready = 1'b1;
                        hwdata_d = wr_data;
                    end
                    state_d = (beats_q == LEN_W'(1)) ? ST_DLAST : ST_ADDR;
                end else begin
                    pend_d  = drive_xfer;
                    state_d = issue ? ST_ADDR : ST_WAITW;
                end
            end
            ST_DLAST: begin
                if (err_first) begin
                    state_d  = ST_ERR;
                    dphase_d = 1'b0;
                end else if (HREADY) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR: begin
                if (HREADY) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            burst_q    <= '0;
            beats_q    <= '0;
            first_q    <= 1'b0;
            pend_q     <= 1'b0;
            dphase_q   <= 1'b0;
            dwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
`ifdef AHB_MGR_MASTLOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            beats_q    <= beats_d;
            first_q    <= first_d;
            pend_q     <= pend_d;
            dphase_q   <= dphase_d;
            dwrite_q   <= dwrite_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
`ifdef AHB_MGR_MASTLOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign HADDR    = addr_q;
    assign HTRANS   = htrans;
    assign HWRITE   = write_q;
    assign HSIZE    = size_q;
    assign HBURST   = burst_q;
    assign HPROT    = HPROT_VAL;
    assign HWDATA   = hwdata_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign done_err = done_err_q;
`ifdef AHB_MGR_MASTLOCK_EN
    // Lock covers every address phase of the command, BUSY included.
    assign HMASTLOCK = lock_q && (htrans != HTRANS_IDLE);
`endif

endmodule

// File: tb/tb_ahb_lite_manager.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_manager
//   Directed bench for ahb_lite_manager. Inputs change 1ns after posedge,
//   outputs are checked at negedge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_manager;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_size = '0;
    logic [4:0]  cmd_len = 5'd1;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        done_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
`ifdef AHB_MGR_MASTLOCK_EN
    logic        cmd_lock = 1'b0;
    logic        HMASTLOCK;
`endif

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_manager dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_len   (cmd_len),
`ifdef AHB_MGR_MASTLOCK_EN
        .cmd_lock  (cmd_lock),
        .HMASTLOCK (HMASTLOCK),
`endif
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .done_err  (done_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    // Present a command for one cycle; returns 1ns after the accepting edge.
    task automatic send_cmd(input logic w, input logic [31:0] a,
                            input logic [2:0] s, input logic [4:0] l);
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_len   = l;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        @(negedge HCLK);
        checks++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST} !== 41'd0) begin
            errors++;
            $display("FAIL reset_bus_ctrl: got trans=%h addr=%h wr=%b size=%h burst=%h, want all 0",
                     HTRANS, HADDR, HWRITE, HSIZE, HBURST);
        end
        checks++;
        if (HWDATA !== 32'd0) begin
            errors++;
            $display("FAIL reset_hwdata: got %h want 0", HWDATA);
        end
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, done, done_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_handshake: got rdy/wrr/rv/done/err=%b want 10000",
                     {cmd_ready, wr_ready, rd_valid, done, done_err});
        end
        checks++;
        if (rd_data !== 32'd0 || HPROT !== 4'b0011) begin
            errors++;
            $display("FAIL reset_rddata_hprot: got rd_data=%h hprot=%h want 0 / 3", rd_data, HPROT);
        end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cyc();
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        @(negedge HCLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_cmd_ready: got %b want 1", cmd_ready);
        end
        send_cmd(1'b1, 32'h100, 3'd2, 5'd1);
        @(negedge HCLK);
        checks++;
        if ({HTRANS, HBURST, HWRITE, HSIZE} !== {2'b10, 3'b000, 1'b1, 3'd2} || HADDR !== 32'h100) begin
            errors++;
            $display("FAIL sw_addr_phase: got trans=%h burst=%h wr=%b size=%h addr=%h want 2/0/1/2/100",
                     HTRANS, HBURST, HWRITE, HSIZE, HADDR);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_wr_ready: got %b want 1", wr_ready);
        end
        cyc();
        wr_valid = 1'b0;
        wr_data  = '0;
        @(negedge HCLK);
        checks++;
        if (HWDATA !== 32'hDEADBEEF || HTRANS !== 2'b00 || done !== 1'b0) begin
            errors++;
            $display("FAIL sw_data_phase: got hwdata=%h trans=%h done=%b want deadbeef/0/0",
                     HWDATA, HTRANS, done);
        end
        cyc();
        @(negedge HCLK);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: got done=%b err=%b cmd_ready=%b want 1/0/0", done, done_err, cmd_ready);
        end
        cyc();
        @(negedge HCLK);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_after_done: got done=%b cmd_ready=%b want 0/1", done, cmd_ready);
        end
        cyc();
    endtask

    task automatic test_single_read_wait();
        int rv_cnt = 0;
        send_cmd(1'b0, 32'h200, 3'd2, 5'd1);
        HREADY = 1'b1;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h200 || HWRITE !== 1'b0) begin
            errors++;
            $display("FAIL sr_addr_phase: got trans=%h addr=%h wr=%b want 2/200/0", HTRANS, HADDR, HWRITE);
        end
        if (rd_valid) rv_cnt++;
        cyc();
        for (int i = 0; i < 2; i++) begin
            HREADY = 1'b0;
            @(negedge HCLK);
            checks++;
            if (HTRANS !== 2'b00 || HSIZE !== 3'd2 || HWRITE !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL sr_wait%0d: got trans=%h size=%h wr=%b done=%b want 0/2/0/0",
                         i, HTRANS, HSIZE, HWRITE, done);
            end
            if (rd_valid) rv_cnt++;
            cyc();
        end
        HREADY = 1'b1;
        HRDATA = 32'h12345678;
        @(negedge HCLK);
        if (rd_valid) rv_cnt++;
        cyc();
        HRDATA = '0;
        @(negedge HCLK);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h12345678 || done !== 1'b1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL sr_result: got rv=%b data=%h done=%b err=%b want 1/12345678/1/0",
                     rd_valid, rd_data, done, done_err);
        end
        if (rd_valid) rv_cnt++;
        cyc();
        @(negedge HCLK);
        if (rd_valid) rv_cnt++;
        checks++;
        if (rv_cnt !== 1) begin
            errors++;
            $display("FAIL sr_rv_count: got %0d want 1", rv_cnt);
        end
        cyc();
    endtask

    task automatic test_addr_hold();
        send_cmd(1'b0, 32'h300, 3'd2, 5'd2);
        HREADY = 1'b1;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b10 || HBURST !== 3'b001) begin
            errors++;
            $display("FAIL ah_first: got trans=%h burst=%h want 2/1", HTRANS, HBURST);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            HREADY = (i == 2);
            HRDATA = (i == 2) ? 32'hA1A1A1A1 : 32'h0;
            @(negedge HCLK);
            checks++;
            if (HTRANS !== 2'b11 || HADDR !== 32'h304) begin
                errors++;
                $display("FAIL ah_hold%0d: got trans=%h addr=%h want 3/304", i, HTRANS, HADDR);
            end
            cyc();
        end
        HRDATA = 32'hA2A2A2A2;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00 || rd_valid !== 1'b1 || rd_data !== 32'hA1A1A1A1) begin
            errors++;
            $display("FAIL ah_beat1: got trans=%h rv=%b data=%h want 0/1/a1a1a1a1", HTRANS, rd_valid, rd_data);
        end
        cyc();
        HRDATA = '0;
        @(negedge HCLK);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hA2A2A2A2 || done !== 1'b1) begin
            errors++;
            $display("FAIL ah_beat2: got rv=%b data=%h done=%b want 1/a2a2a2a2/1", rd_valid, rd_data, done);
        end
        cyc();
    endtask

    task automatic test_incr4_write_busy();
        logic        wv_t [7]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] wd_t [7]   = '{32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA2, 32'hA3, 32'h0};
        logic [1:0]  exp_tr [7] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
        logic [31:0] exp_ad [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC};
        logic        exp_wr [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_hw [7] = '{32'h0, 32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2, 32'hA3};
        int wr_cnt = 0;
        send_cmd(1'b1, 32'h0, 3'd2, 5'd4);
        for (int i = 0; i < 7; i++) begin
            wr_valid = wv_t[i];
            wr_data  = wd_t[i];
            @(negedge HCLK);
            checks++;
            if (HTRANS !== exp_tr[i] || wr_ready !== exp_wr[i]) begin
                errors++;
                $display("FAIL i4_cycle%0d: got trans=%h wr_ready=%b want %h/%b",
                         i, HTRANS, wr_ready, exp_tr[i], exp_wr[i]);
            end
            if (i < 6) begin
                checks++;
                if (HADDR !== exp_ad[i] || HBURST !== 3'b011) begin
                    errors++;
                    $display("FAIL i4_addr%0d: got addr=%h burst=%h want %h/3", i, HADDR, HBURST, exp_ad[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (HWDATA !== exp_hw[i]) begin
                    errors++;
                    $display("FAIL i4_hwdata%0d: got %h want %h", i, HWDATA, exp_hw[i]);
                end
            end
            if (wr_ready) wr_cnt++;
            cyc();
        end
        wr_valid = 1'b0;
        @(negedge HCLK);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b0 || wr_cnt !== 4) begin
            errors++;
            $display("FAIL i4_done: got done=%b err=%b wr_ready_pulses=%0d want 1/0/4", done, done_err, wr_cnt);
        end
        cyc();
    endtask

    task automatic test_incr8_read_err();
        int rv_cnt = 0;
        int late_xfer = 0;
        send_cmd(1'b0, 32'h40, 3'd2, 5'd8);
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h40 || HBURST !== 3'b101) begin
            errors++;
            $display("FAIL i8_first: got trans=%h addr=%h burst=%h want 2/40/5", HTRANS, HADDR, HBURST);
        end
        cyc();
        HRDATA = 32'hCAFE0001;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b11 || HADDR !== 32'h44) begin
            errors++;
            $display("FAIL i8_second: got trans=%h addr=%h want 3/44", HTRANS, HADDR);
        end
        cyc();
        HRDATA = '0;
        HREADY = 1'b0;
        HRESP  = 1'b1;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL i8_err1_idle: got trans=%h want 0", HTRANS);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL i8_beat1_data: got rv=%b data=%h want 1/cafe0001", rd_valid, rd_data);
        end
        if (rd_valid) rv_cnt++;
        cyc();
        HREADY = 1'b1;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00 || done !== 1'b0) begin
            errors++;
            $display("FAIL i8_err2: got trans=%h done=%b want 0/0", HTRANS, done);
        end
        if (rd_valid) rv_cnt++;
        cyc();
        HRESP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            if (HTRANS !== 2'b00) late_xfer++;
            if (rd_valid) rv_cnt++;
            checks++;
            if (done !== (i == 0) || (i == 0 && done_err !== 1'b1)) begin
                errors++;
                $display("FAIL i8_done%0d: got done=%b err=%b want %b/1", i, done, done_err, (i == 0));
            end
            cyc();
        end
        checks++;
        if (rv_cnt !== 1 || late_xfer !== 0) begin
            errors++;
            $display("FAIL i8_totals: got rd_valid=%0d late_transfers=%0d want 1/0", rv_cnt, late_xfer);
        end
    endtask

    task automatic test_1k_cross();
        logic [1:0] exp_tr [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
        int rv_cnt = 0;
        send_cmd(1'b0, 32'h3F8, 3'd2, 5'd6);
        for (int i = 0; i < 9; i++) begin
            HRDATA = 32'h1000 + 32'(i);
            @(negedge HCLK);
            if (i < 6) begin
                checks++;
                if (HTRANS !== exp_tr[i] || HADDR !== 32'h3F8 + 32'(4 * i) || HBURST !== 3'b001) begin
                    errors++;
                    $display("FAIL kb_beat%0d: got trans=%h addr=%h burst=%h want %h/%h/1",
                             i, HTRANS, HADDR, HBURST, exp_tr[i], 32'h3F8 + 32'(4 * i));
                end
            end
            if (rd_valid) begin
                rv_cnt++;
                checks++;
                if (rd_data !== 32'h1000 + 32'(i - 1)) begin
                    errors++;
                    $display("FAIL kb_rdata%0d: got %h want %h", i, rd_data, 32'h1000 + 32'(i - 1));
                end
            end
            if (i == 7) begin
                checks++;
                if (done !== 1'b1 || done_err !== 1'b0) begin
                    errors++;
                    $display("FAIL kb_done: got done=%b err=%b want 1/0", done, done_err);
                end
            end
            cyc();
        end
        HRDATA = '0;
        checks++;
        if (rv_cnt !== 6) begin
            errors++;
            $display("FAIL kb_rv_count: got %0d want 6", rv_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        wr_valid = 1'b1;
        wr_data  = 32'h11111111;
        send_cmd(1'b1, 32'h80, 3'd2, 5'd4);
        cyc();
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b11 || HADDR !== 32'h84) begin
            errors++;
            $display("FAIL rm_beat2: got trans=%h addr=%h want 3/84", HTRANS, HADDR);
        end
        #1;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWDATA !== 32'h0 || HBURST !== 3'b000) begin
            errors++;
            $display("FAIL rm_bus_reset: got trans=%h addr=%h hwdata=%h burst=%h want 0/0/0/0",
                     HTRANS, HADDR, HWDATA, HBURST);
        end
        checks++;
        if (cmd_ready !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rm_hs_reset: got cmd_ready=%b wr_ready=%b want 1/0", cmd_ready, wr_ready);
        end
        cyc();
        wr_valid = 1'b0;
        HRESETn  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            if (done) done_cnt++;
            cyc();
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL rm_no_done: got %0d done pulses want 0", done_cnt);
        end
        // New command, write data arrives one cycle late.
        send_cmd(1'b1, 32'h10, 3'd2, 5'd1);
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL rm_starve_idle: got trans=%h wr_ready=%b want 0/0", HTRANS, wr_ready);
        end
        cyc();
        wr_valid = 1'b1;
        wr_data  = 32'h55AA55AA;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h10 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_new_addr: got trans=%h addr=%h wr_ready=%b want 2/10/1", HTRANS, HADDR, wr_ready);
        end
        cyc();
        wr_valid = 1'b0;
        @(negedge HCLK);
        checks++;
        if (HWDATA !== 32'h55AA55AA || HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL rm_new_data: got hwdata=%h trans=%h want 55aa55aa/0", HWDATA, HTRANS);
        end
        cyc();
        @(negedge HCLK);
        checks++;
        if (done !== 1'b1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL rm_new_done: got done=%b err=%b want 1/0", done, done_err);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read_wait();
        test_addr_hold();
        test_incr4_write_busy();
        test_incr8_read_err();
        test_1k_cross();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
